// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencer for the iterative AES encryption core.
// Steps the shared round datapath through the initial key addition, NR-1 full
// rounds and the final round (no MixColumns), then offers the ciphertext over
// a valid/ready handshake. Control only: it produces selects, enables and the
// round index that the key schedule uses to present the matching round key.
module aes_round_ctrl #(
  parameter int unsigned NR = 10  // 10/12/14 for AES-128/192/256, legal 2..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       abort,
  output logic       load_state,
  output logic       state_en,
  output logic       skip_mix,
  output logic [3:0] round,
  output logic       busy,
  output logic       done_valid,
  input  logic       done_ready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Index of the final round and of the last round that still uses MixColumns.
  localparam logic [3:0] ROUND_LAST  = 4'(NR);
  localparam logic [3:0] ROUND_PENUL = 4'(NR - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;

  // State and round counter registers; reset lands in IDLE with round 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state, round counter update and fully decoded datapath controls.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    start_ready = 1'b0;
    load_state  = 1'b0;
    state_en    = 1'b0;
    skip_mix    = 1'b0;
    busy        = 1'b0;
    done_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        round_d     = 4'd0;
        if (start_valid) begin
          state_d = ST_INIT;
        end
      end

      // Initial AddRoundKey: the state register takes the input block
      // XORed with round key 0.
      ST_INIT: begin
        load_state = 1'b1;
        state_en   = 1'b1;
        busy       = 1'b1;
        state_d    = ST_ROUND;
        round_d    = 4'd1;
      end

      // Full rounds 1..NR-1. The >= compare keeps the counter from running
      // past NR even if it were ever disturbed.
      ST_ROUND: begin
        state_en = 1'b1;
        busy     = 1'b1;
        if (round_q >= ROUND_PENUL) begin
          state_d = ST_FINAL;
          round_d = ROUND_LAST;
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      // Final round bypasses MixColumns.
      ST_FINAL: begin
        state_en = 1'b1;
        skip_mix = 1'b1;
        busy     = 1'b1;
        state_d  = ST_DONE;
        round_d  = ROUND_LAST;
      end

      // Hold the ciphertext until consumed; a start presented together with
      // done_ready is taken immediately for back-to-back blocks.
      ST_DONE: begin
        done_valid  = 1'b1;
        start_ready = done_ready;
        round_d     = ROUND_LAST;
        if (done_ready) begin
          round_d = 4'd0;
          state_d = start_valid ? ST_INIT : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        round_d = 4'd0;
      end
    endcase

    // Cancel wins over everything else, including a pending result.
    if (abort) begin
      state_d = ST_IDLE;
      round_d = 4'd0;
    end
  end

  assign round = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three instances (NR=10/12/14), a behavioural AES
// datapath driven by the NR=10 instance's controls, and a queue of per-cycle
// expected control vectors that is filled when a start is driven.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R0  = 128'h00102030405060708090a0b0c0d0e0f0;

  logic       clk;
  logic       rst_n;
  logic       sv [3];
  logic       ab [3];
  logic       dr [3];
  logic       sr [3];
  logic       ls [3];
  logic       se [3];
  logic       sm [3];
  logic       bz [3];
  logic       dv [3];
  logic [3:0] rd [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [9:0]   exp_q[$];
  logic [7:0]   sb [256];
  logic [127:0] rk [16];
  logic [127:0] aes_st;

  aes_round_ctrl #(.NR(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
    .abort(ab[0]), .load_state(ls[0]), .state_en(se[0]), .skip_mix(sm[0]),
    .round(rd[0]), .busy(bz[0]), .done_valid(dv[0]), .done_ready(dr[0]));

  aes_round_ctrl #(.NR(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
    .abort(ab[1]), .load_state(ls[1]), .state_en(se[1]), .skip_mix(sm[1]),
    .round(rd[1]), .busy(bz[1]), .done_valid(dv[1]), .done_ready(dr[1]));

  aes_round_ctrl #(.NR(14)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(sr[2]),
    .abort(ab[2]), .load_state(ls[2]), .state_en(se[2]), .skip_mix(sm[2]),
    .round(rd[2]), .busy(bz[2]), .done_valid(dv[2]), .done_ready(dr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES reference datapath ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  // State register of the datapath, steered only by the NR=10 controller.
  always @(posedge clk) begin
    if (se[0]) begin
      if (ls[0]) aes_st <= PT ^ rk[rd[0]];
      else       aes_st <= aes_round(aes_st, sm[0]) ^ rk[rd[0]];
    end
  end

  task automatic build_tables();
    logic [7:0]  inv;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int x = 1; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    sb[0] = 8'h63;
    w[0] = KEY[127:96]; w[1] = KEY[95:64]; w[2] = KEY[63:32]; w[3] = KEY[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Vector layout: {round[3:0], load_state, state_en, skip_mix, busy, done_valid, start_ready}
  function automatic logic [9:0] mkvec(input int r, input bit l, input bit e, input bit s,
                                       input bit b, input bit d, input bit rdy);
    return {4'(r), l, e, s, b, d, rdy};
  endfunction

  function automatic logic [9:0] obs_vec(input int d);
    return {rd[d], ls[d], se[d], sm[d], bz[d], dv[d], sr[d]};
  endfunction

  // Expected cycles after an accepted start: INIT, rounds 1..nr-1, FINAL, first DONE.
  task automatic push_block(input int nr, input bit rdy, input int ncyc);
    logic [9:0] v [$];
    v.push_back(mkvec(0, 1, 1, 0, 1, 0, 0));
    for (int r = 1; r < nr; r++) v.push_back(mkvec(r, 0, 1, 0, 1, 0, 0));
    v.push_back(mkvec(nr, 0, 1, 1, 1, 0, 0));
    v.push_back(mkvec(nr, 0, 0, 0, 0, 1, rdy));
    for (int i = 0; i < ncyc && i < v.size(); i++) exp_q.push_back(v[i]);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mkvec(0, 0, 0, 0, 0, 0, 1));
  endtask

  // Compare one queued vector per cycle; start_valid drops after clr_idx and
  // abort is raised for exactly the cycle after abort_idx.
  task automatic drain(input int d, input string tag, input int clr_idx, input int abort_idx,
                       input bit kat, output int se_cnt, output int dv_idx, output int dv_round);
    int n;
    logic [9:0] e;
    n = exp_q.size();
    se_cnt = 0; dv_idx = -1; dv_round = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d", tag, i), 128'(obs_vec(d)), 128'(e));
      if (se[d]) se_cnt++;
      if (dv[d] && dv_idx < 0) begin
        dv_idx = i;
        dv_round = int'(rd[d]);
      end
      if (kat && i == 2) check({tag, "_round0"}, aes_st, R0);
      if (i == clr_idx) sv[d] = 1'b0;
      ab[d] = (i == abort_idx);
    end
    $display("txn %s: dut%0d cycles=%0d latency=%0d state_en=%0d final_round=%0d",
             tag, d, n, dv_idx, se_cnt, dv_round);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int sec, dvi, dvr;
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0; ab[k] = 1'b0; dr[k] = 1'b0;
    end
    rst_n = 1'b1;
    build_tables();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_dut%0d", k), 128'(obs_vec(k)), 128'(mkvec(0, 0, 0, 0, 0, 0, 1)));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 128'(obs_vec(0)), 128'(mkvec(0, 0, 0, 0, 0, 0, 1)));

    // Single block, known-answer ciphertext.
    dr[0] = 1'b1; sv[0] = 1'b1;
    push_block(10, 1'b1, 12); push_idle(1);
    drain(0, "single", 1, 0, 1'b1, sec, dvi, dvr);
    check("single_latency", dvi, 12);
    check("single_state_en", sec, 11);
    check("single_final_round", dvr, 10);
    check("single_ciphertext", aes_st, CT);

    // Backpressure, then release with a start in the same cycle.
    dr[0] = 1'b0; sv[0] = 1'b1;
    push_block(10, 1'b0, 12);
    drain(0, "bp", 1, 0, 1'b0, sec, dvi, dvr);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), 128'(obs_vec(0)), 128'(mkvec(10, 0, 0, 0, 0, 1, 0)));
    end
    dr[0] = 1'b1; sv[0] = 1'b1;
    #1 check("bp_start_ready", 128'(sr[0]), 128'(1'b1));
    push_block(10, 1'b1, 12); push_idle(1);
    drain(0, "bp_b2b", 1, 0, 1'b1, sec, dvi, dvr);
    check("bp_b2b_latency", dvi, 12);
    check("bp_b2b_ciphertext", aes_st, CT);

    // Two blocks back-to-back with start_valid and done_ready held high.
    sv[0] = 1'b1;
    push_block(10, 1'b1, 12); push_block(10, 1'b1, 12); push_idle(1);
    drain(0, "thru", 24, 0, 1'b0, sec, dvi, dvr);
    check("thru_state_en", sec, 22);
    check("thru_first_done", dvi, 12);

    // Abort during round 4: IDLE next cycle and no result afterwards.
    sv[0] = 1'b1;
    push_block(10, 1'b1, 5); push_idle(12);
    drain(0, "abort_r4", 1, 5, 1'b0, sec, dvi, dvr);
    check("abort_r4_no_done", dvi, -1);

    // Abort while the result waits in DONE.
    dr[0] = 1'b0; sv[0] = 1'b1;
    push_block(10, 1'b0, 12); push_idle(3);
    drain(0, "abort_done", 1, 12, 1'b0, sec, dvi, dvr);
    check("abort_done_dv_idx", dvi, 12);

    // Asynchronous reset during round 6, then a normal block.
    dr[0] = 1'b1; sv[0] = 1'b1;
    push_block(10, 1'b1, 7);
    drain(0, "pre_arst", 1, 0, 1'b0, sec, dvi, dvr);
    #2 rst_n = 1'b0;
    #1 check("arst_immediate", 128'(obs_vec(0)), 128'(mkvec(0, 0, 0, 0, 0, 0, 1)));
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3);
    drain(0, "post_arst", 0, 0, 1'b0, sec, dvi, dvr);
    check("post_arst_no_done", dvi, -1);
    sv[0] = 1'b1;
    push_block(10, 1'b1, 12); push_idle(1);
    drain(0, "restart", 1, 0, 1'b0, sec, dvi, dvr);
    check("restart_latency", dvi, 12);
    check("restart_ciphertext", aes_st, CT);

    // Parameter sweep.
    dr[1] = 1'b1; sv[1] = 1'b1;
    push_block(12, 1'b1, 14); push_idle(1);
    drain(1, "nr12", 1, 0, 1'b0, sec, dvi, dvr);
    check("nr12_latency", dvi, 14);
    check("nr12_final_round", dvr, 12);
    check("nr12_state_en", sec, 13);

    dr[2] = 1'b1; sv[2] = 1'b1;
    push_block(14, 1'b1, 16); push_idle(1);
    drain(2, "nr14", 1, 0, 1'b0, sec, dvi, dvr);
    check("nr14_latency", dvi, 16);
    check("nr14_final_round", dvr, 14);
    check("nr14_state_en", sec, 15);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
